pla_pipe: RTL and testbench

Parametrised, runtime-programmable PLA (AND plane plus OR plane) that evaluates up to N_OUT sum-of-products functions of N_IN inputs.
- Two-stage pipeline with valid/ready handshakes on input and output.
- Serves as the general replacement for fixed gate-level function blocks: any multi-level function such as F = A(B + CD) + B·C' is loaded as product terms through a configuration port.
- Sits between a stimulus or register source and a consumer that may stall.

---
 rtl/pla_pipe.sv | 133 +++++++++++++
 tb/tb_pla_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_pipe.sv
// pla_pipe: runtime-programmable PLA (AND plane + OR plane) behind a
// two-stage valid/ready pipeline. Product terms and output term-selects
// are loaded through a small configuration port. Writes are only accepted
// when the pipeline is empty, so every vector sees a single configuration.
module pla_pipe #(
   parameter int N_IN   = 4,
   parameter int N_TERM = 8,
   parameter int N_OUT  = 2,
   localparam int CW    = (2 * N_IN > N_TERM) ? 2 * N_IN : N_TERM,
   localparam int AW    = $clog2(N_TERM + N_OUT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we_i,
   input  logic [AW-1:0]     cfg_addr_i,
   input  logic [CW-1:0]     cfg_wdata_i,
   output logic              cfg_ready_o,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [N_IN-1:0]   in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [N_OUT-1:0]  out_data_o
);

   logic [N_TERM-1:0][N_IN-1:0]  tmask_q;
   logic [N_TERM-1:0][N_IN-1:0]  cmask_q;
   logic [N_OUT-1:0][N_TERM-1:0] omask_q;

   logic                s1_valid_q, s1_valid_d;
   logic [N_TERM-1:0]   term_q, term_d;
   logic                out_valid_q, out_valid_d;
   logic [N_OUT-1:0]    out_data_q, out_data_d;

   logic        s2_free;
   logic        s1_adv;
   logic        in_fire;
   logic        cfg_fire;
   logic [31:0] addr_ext;

   assign s2_free     = ~out_valid_q | out_ready_i;
   assign s1_adv      = s1_valid_q & s2_free;
   assign in_ready_o  = ~cfg_we_i & (~s1_valid_q | s2_free);
   assign in_fire     = in_valid_i & in_ready_o;
   assign cfg_ready_o = ~s1_valid_q & ~out_valid_q;
   assign cfg_fire    = cfg_we_i & cfg_ready_o;
   assign addr_ext    = 32'(cfg_addr_i);

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   // Mask registers; out-of-range addresses match no entry and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmask_q <= '0;
         cmask_q <= '0;
         omask_q <= '0;
      end else if (cfg_fire) begin
         for (int k = 0; k < N_TERM; k++) begin
            if (addr_ext == 32'(k)) begin
               tmask_q[k] <= cfg_wdata_i[N_IN-1:0];
               cmask_q[k] <= cfg_wdata_i[2*N_IN-1:N_IN];
            end
         end
         for (int j = 0; j < N_OUT; j++) begin
            if (addr_ext == 32'(N_TERM + j)) begin
               omask_q[j] <= cfg_wdata_i[N_TERM-1:0];
            end
         end
      end
   end

   // AND plane: a term with no literals is disabled (0) rather than a constant 1.
   always_comb begin
      term_d = '0;
      for (int k = 0; k < N_TERM; k++) begin
         term_d[k] = (|(tmask_q[k] | cmask_q[k]))
                   & (&((~tmask_q[k] | in_data_i) & (~cmask_q[k] | ~in_data_i)));
      end
   end

   // OR plane over the registered terms.
   always_comb begin
      out_data_d = '0;
      for (int j = 0; j < N_OUT; j++) begin
         out_data_d[j] = |(omask_q[j] & term_q);
      end
   end

   // Pipeline occupancy: stage 1 fills on accept, empties on advance;
   // stage 2 fills on advance, empties when the consumer takes it.
   always_comb begin
      s1_valid_d = s1_valid_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      out_valid_d = out_valid_q;
      if (s1_adv) begin
         out_valid_d = 1'b1;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // Stage 1 register: captures the AND-plane result on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         term_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_fire) begin
            term_q <= term_d;
         end
      end
   end

   // Stage 2 register: captures the OR-plane result on advance, holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (s1_adv) begin
            out_data_q <= out_data_d;
         end
      end
   end

endmodule

// File: tb/tb_pla_pipe.sv
// Bench for pla_pipe with default parameters (4 inputs, 8 terms, 2 outputs).
module tb_pla_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_addr = '0;
   logic [7:0] cfg_wdata = '0;
   logic       cfg_ready;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [1:0] out_data;

   pla_pipe dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_we_i    (cfg_we),
      .cfg_addr_i  (cfg_addr),
      .cfg_wdata_i (cfg_wdata),
      .cfg_ready_o (cfg_ready),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] din;
      logic [1:0] exp;
   } vec_t;

   vec_t       tbl[16];
   logic [1:0] q_exp[$];
   int         q_edge[$];
   logic [1:0] exp_cur = '0;
   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         n_acc = 0;
   int         last_acc = 0;
   bit         lat_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic f_ref(input logic [3:0] x);
      logic a, b, c, d;
      a = x[0]; b = x[1]; c = x[2]; d = x[3];
      return (a & (b | (c & d))) | (b & ~c);
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard: inputs and outputs are stable at the falling edge and
   // transfer on the following rising edge (edge number cyc+1).
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            q_exp.push_back(exp_cur);
            q_edge.push_back(cyc + 1);
            n_acc++;
            last_acc = cyc + 1;
         end
         if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL spurious_out: got data %0h, expected no output", out_data);
            end else begin
               logic [1:0] e;
               int         a;
               e = q_exp.pop_front();
               a = q_edge.pop_front();
               check("out_data", int'(out_data), int'(e));
               if (lat_en) check("latency", cyc + 1 - a, 2);
            end
         end
      end
   end

   task automatic send_vec(input logic [3:0] d, input logic [1:0] e);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      exp_cur  = e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
      int n;
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      n = 0;
      do begin
         @(negedge clk);
         check("in_ready_during_cfg", int'(in_ready), 0);
         n++;
      end while (!cfg_ready && n < 200);
      if (!cfg_ready) check("cfg_timeout", 0, 1);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((q_exp.size() != 0 || out_valid) && n < 200);
      check("drain_queue_left", q_exp.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_table();
      for (int i = 0; i < 16; i++) send_vec(tbl[i].din, tbl[i].exp);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] held;
      int         t0, base;

      for (int i = 0; i < 16; i++) begin
         tbl[i].din = 4'(i);
         tbl[i].exp = {1'b0, f_ref(4'(i))};
      end

      // Reset defaults
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_cfg_ready", int'(cfg_ready), 1);
      check("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Cleared masks: all-ones input still gives 0
      send_vec(4'hF, 2'b00);
      in_valid = 1'b0;
      drain();

      // Load F = AB + ACD + BC'
      cfg_write(4'd0, 8'h03);
      cfg_write(4'd1, 8'h0D);
      cfg_write(4'd2, 8'h42);
      cfg_write(4'd8, 8'h07);

      // Full-rate sweep: latency 2 and 1 vector/cycle
      lat_en = 1'b1;
      send_vec(tbl[0].din, tbl[0].exp);
      t0 = last_acc;
      for (int i = 1; i < 16; i++) send_vec(tbl[i].din, tbl[i].exp);
      in_valid = 1'b0;
      check("throughput_edges", last_acc - t0, 15);
      drain();
      lat_en = 1'b0;

      // Backpressure during a sweep
      base = n_acc;
      out_ready = 1'b0;
      fork
         run_table();
         begin
            repeat (3) @(negedge clk);
            check("stall_accepts", n_acc - base, 2);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            held = out_data;
            repeat (2) @(negedge clk);
            check("stall_hold", int'(out_data), int'(held));
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(negedge clk);
            check("release_in_ready", int'(in_ready), 1);
         end
      join
      drain();

      // Config gating: write to output 1 while both stages hold data
      out_ready = 1'b0;
      send_vec(4'b0011, 2'b01);
      send_vec(4'b0011, 2'b01);
      in_valid = 1'b0;
      fork
         cfg_write(4'd9, 8'h01);
         begin
            repeat (3) begin
               @(negedge clk);
               check("gate_cfg_ready", int'(cfg_ready), 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      send_vec(4'b0011, 2'b11);
      send_vec(4'b0001, 2'b00);
      send_vec(4'b0010, 2'b01);
      in_valid = 1'b0;
      drain();

      // Term edge cases: contradictory term, disabled term, out-of-range address
      cfg_write(4'd3, 8'h11);
      cfg_write(4'd9, 8'h08);
      run_table();
      drain();
      cfg_write(4'd3, 8'h00);
      run_table();
      drain();
      cfg_write(4'd10, 8'hFF);
      run_table();
      drain();

      // Reset mid-stream discards vectors and configuration
      out_ready = 1'b0;
      send_vec(4'hF, 2'b01);
      send_vec(4'b0010, 2'b01);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_data", int'(out_data), 0);
      check("midrst_cfg_ready", int'(cfg_ready), 1);
      check("midrst_in_ready", int'(in_ready), 1);
      q_exp.delete();
      q_edge.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send_vec(4'hF, 2'b00);
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
